mrisc_trace_monitor: RTL
========================

# mrisc_trace_monitor

Synthesizable run-control and trace unit for the 16-bit mRisc core, and the parametrised successor of the bench-side halt/stage-count logic. It sits beside the core on the instruction-retire and memory-write buses. It counts cycles and retired instructions, and detects the halt instruction, finishing after a programmable drain. It records a circular trace of the most recent events that a host or bench reads back after the run.

## Interface
- DATA_W, 16, instruction/data width
- ADDR_W, 16, PC and memory address width
- DEPTH, 16, trace entries; power of two, ≥2
- HALT_INSTR, 16'h2fff, encoding that triggers halt
- HALT_DELAY, 4, drain cycles between halt detect and done; 0..255
- CNT_W, 32, width of cycle and instruction counters

Ports:
- CLK  in  1  core clock
- RST_N  in  1  asynchronous, active-low reset
- clr  in  1  synchronous restart: same effect as reset, one cycle
- ret_valid  in  1  instruction retires this cycle
- ret_instr  in  DATA_W  retiring instruction word
- ret_pc  in  ADDR_W  PC of retiring instruction
- mem_we  in  1  core memory write strobe
- mem_addr  in  ADDR_W  write address
- mem_wdata  in  DATA_W  write data
- rd_idx  in  $clog2(DEPTH)  trace index, 0 = oldest valid entry
- rd_tag  out  1  0 = instruction entry, 1 = memory-write entry
- rd_addr  out  ADDR_W  PC or write address of entry
- rd_data  out  DATA_W  instruction word or write data
- cyc_cnt  out  CNT_W  cycles since reset/clr
- ins_cnt  out  CNT_W  retired instructions
- n_valid  out  $clog2(DEPTH)+1  valid entries, saturates at DEPTH
- wrapped  out  1  buffer has overwritten at least one entry
- halted  out  1  halt detected, in DRAIN or DONE
- done  out  1  run finished

## Operation
- States: RUN, DRAIN, DONE.
- RUN:
  - cyc_cnt +1 every cycle; ins_cnt +1 on ret_valid.
  - Each event writes one trace entry at wr_ptr, then wr_ptr +1 mod DEPTH.
  - Matching ret_valid with ret_instr==HALT_INSTR is traced and counted, sets halted, and loads drain=HALT_DELAY.
    - HALT_DELAY=0: next state DONE.
    - Otherwise: next state DRAIN.
- DRAIN: counting and tracing continue; drain −1 per cycle; at drain==1 move to DONE. A second halt instruction during DRAIN is traced but does not reload drain.
- DONE: done=1; counters, trace writes and wr_ptr frozen; exit only via RST_N or clr.
- n_valid +1 per write until DEPTH. wrapped is set on the first write when n_valid==DEPTH.
- Read address = (wrapped ? wr_ptr : 0) + rd_idx, mod DEPTH. rd_idx ≥ n_valid returns all-zero outputs.
- Counters wrap modulo 2^CNT_W with no flag.
- RST_N low mid-run from any state: immediate return to RUN with every output zero.

## Timing
- Reset values: all outputs 0, state RUN, wr_ptr 0, trace contents don't-care.
- Trace write takes effect at the CLK edge of the event. An entry is readable at rd_idx from the following cycle.
- Read latency: one cycle, registered from rd_idx (reset 0).
- halted rises the edge after the halt retire. done rises HALT_DELAY+1 edges after the halt retire.
- cyc_cnt counts the halt cycle and all DRAIN cycles. At done it equals (cycle index of halt retire + HALT_DELAY + 1).
- clr has priority over all events in the same cycle.

## Configuration
- TRACE_MEMWR_EN defined: mem_we events are traced with tag 1.
  - If ret_valid and mem_we coincide, the instruction entry is written first and the memory-write entry second; two entries, wr_ptr +2, n_valid +2 (saturating).
- Undefined: mem_we, mem_addr and mem_wdata are ignored; rd_tag is tied 0; one write port only.

## Structure
- Package mrisc_dbg_pkg:
  - state enum (RUN, DRAIN, DONE)
  - tag constants TAG_INSTR/TAG_MEMWR
  - default HALT_INSTR
  - trace-entry packed struct {tag, addr, data}
- Sub-module mrisc_trace_ram: DEPTH×(1+ADDR_W+DATA_W) storage with two write ports (second present only under TRACE_MEMWR_EN) and one registered read port.
- Top holds the FSM, counters, pointers and read-address arithmetic.

## Test plan
- Reset, then 5 idle cycles → cyc_cnt=5, ins_cnt=0, n_valid=0, done=0, rd_* all 0.
- Retire 3 instructions with PC 0,1,2, then 2fff at PC 3, HALT_DELAY=4 → halted next edge, done 5 edges after halt, ins_cnt=4, n_valid=4, rd_idx=3 gives addr 3 / data 2fff.
- Retire 20 instructions with DEPTH=16 → wrapped=1, n_valid=16, rd_idx=0 returns the 5th instruction (PC 4), rd_idx=15 returns PC 19.
- Under TRACE_MEMWR_EN: ret_valid with mem_we (addr 03e7, data 00aa) in one cycle → two entries; instruction at idx 0 (tag 0), memory write at idx 1 (tag 1, 03e7/00aa).
- Assert RST_N low in the second DRAIN cycle → all outputs 0 immediately; a later halt restarts the full drain.
- HALT_DELAY=0 → done the edge after the halt retire; further retires are neither counted nor traced; clr returns to RUN.

Source files
------------

// File: rtl/mrisc_dbg_pkg.sv
// Shared types and constants for the mRisc run-control / trace monitor.
// Holds the FSM state enum, trace tags, default halt word and entry layout.
package mrisc_dbg_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic TAG_INSTR = 1'b0;
    localparam logic TAG_MEMWR = 1'b1;

    localparam int TRACE_AW = 16;
    localparam int TRACE_DW = 16;

    localparam logic [TRACE_DW-1:0] DEF_HALT_INSTR = 16'h2fff;

    // One trace word at the default address/data widths.
    typedef struct packed {
        logic                tag;
        logic [TRACE_AW-1:0] addr;
        logic [TRACE_DW-1:0] data;
    } trace_entry_t;

endpackage

// File: rtl/mrisc_trace_monitor_if.sv
// Core-side retire and memory-write bus observed by the trace monitor.
// master: the core drives it; slave: the monitor samples it.
interface mrisc_trace_monitor_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);

    logic              ret_valid;
    logic [DATA_W-1:0] ret_instr;
    logic [ADDR_W-1:0] ret_pc;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    modport master (
        output ret_valid, ret_instr, ret_pc,
        output mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input ret_valid, ret_instr, ret_pc,
        input mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mrisc_trace_ram.sv
// Trace storage: DEPTH words, write port A always, write port B only with
// TRACE_MEMWR_EN, one registered read port (zeroed when rd_en is low or clr).
module mrisc_trace_ram #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 33,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             clr,
    input  logic             wa_en,
    input  logic [AW-1:0]    wa_addr,
    input  logic [WIDTH-1:0] wa_data,
`ifdef TRACE_MEMWR_EN
    input  logic             wb_en,
    input  logic [AW-1:0]    wb_addr,
    input  logic [WIDTH-1:0] wb_data,
`endif
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;
    logic [WIDTH-1:0] rd_data_d;

    // Contents need no reset; validity is tracked by the owner.
    always_ff @(posedge CLK) begin
        if (wa_en) mem_q[wa_addr] <= wa_data;
`ifdef TRACE_MEMWR_EN
        if (wb_en) mem_q[wb_addr] <= wb_data;
`endif
    end

    always_comb begin
        rd_data_d = '0;
        if (rd_en && !clr) rd_data_d = mem_q[rd_addr];
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) rd_data_q <= '0;
        else        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/mrisc_trace_monitor.sv
// Run-control and circular trace for the mRisc core: cycle/instr counters,
// halt detect with programmable drain, readback of the most recent events.
// Ports: CLK, RST_N (async low), clr (sync restart), bus (retire/mem-write
// slave), rd_idx -> rd_tag/rd_addr/rd_data (1-cycle latency), cyc_cnt,
// ins_cnt, n_valid, wrapped, halted, done.
// Macro TRACE_MEMWR_EN: also trace memory writes (tag 1), second write port.
module mrisc_trace_monitor
    import mrisc_dbg_pkg::*;
#(
    parameter  int                DATA_W     = 16,
    parameter  int                ADDR_W     = 16,
    parameter  int                DEPTH      = 16,
    parameter  logic [DATA_W-1:0] HALT_INSTR = DATA_W'(DEF_HALT_INSTR),
    parameter  int                HALT_DELAY = 4,
    parameter  int                CNT_W      = 32,
    localparam int                IW         = $clog2(DEPTH),
    localparam int                NW         = IW + 1
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               clr,
    mrisc_trace_monitor_if.slave bus,
    input  logic [IW-1:0]      rd_idx,
    output logic               rd_tag,
    output logic [ADDR_W-1:0]  rd_addr,
    output logic [DATA_W-1:0]  rd_data,
    output logic [CNT_W-1:0]   cyc_cnt,
    output logic [CNT_W-1:0]   ins_cnt,
    output logic [NW-1:0]      n_valid,
    output logic               wrapped,
    output logic               halted,
    output logic               done
);

`ifdef TRACE_MEMWR_EN
    localparam int ENTRY_W = 1 + ADDR_W + DATA_W;
`else
    localparam int ENTRY_W = ADDR_W + DATA_W;
`endif

    localparam logic [NW:0]   DEPTH_X = (NW+1)'(DEPTH);
    localparam logic [NW-1:0] DEPTH_N = NW'(DEPTH);
    localparam logic [7:0]    HD8     = 8'(HALT_DELAY);

    state_e             state_q, state_d;
    logic [7:0]         drain_q, drain_d;
    logic [CNT_W-1:0]   cyc_q, cyc_d;
    logic [CNT_W-1:0]   ins_q, ins_d;
    logic [IW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [NW-1:0]      nv_q, nv_d;
    logic               wrapped_q, wrapped_d;

    logic               active;
    logic               ins_ev;
    logic               mem_ev;
    logic               is_halt;
    logic [1:0]         n_wr;
    logic [NW:0]        nv_sum;

    logic               wa_en;
    logic [ENTRY_W-1:0] wa_data;
    logic               rd_en;
    logic [IW-1:0]      raddr;
    logic [ENTRY_W-1:0] rd_word;

    // DONE freezes every counter, pointer and trace write.
    assign active  = (state_q != ST_DONE);
    assign ins_ev  = bus.ret_valid && active;
    assign is_halt = ins_ev && (bus.ret_instr == HALT_INSTR);

`ifdef TRACE_MEMWR_EN
    assign mem_ev = bus.mem_we && active;
`else
    logic unused_mem;
    assign mem_ev     = 1'b0;
    assign unused_mem = ^{bus.mem_we, bus.mem_addr, bus.mem_wdata};
`endif

    assign n_wr   = {1'b0, ins_ev} + {1'b0, mem_ev};
    assign nv_sum = {1'b0, nv_q} + {{(NW-1){1'b0}}, n_wr};

    always_comb begin
        state_d   = state_q;
        drain_d   = drain_q;
        cyc_d     = cyc_q;
        ins_d     = ins_q;
        wr_ptr_d  = wr_ptr_q;
        nv_d      = nv_q;
        wrapped_d = wrapped_q;

        unique case (state_q)
            ST_RUN: begin
                if (is_halt) begin
                    drain_d = HD8;
                    state_d = (HALT_DELAY == 0) ? ST_DONE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // A repeated halt here is traced but never reloads drain.
                drain_d = drain_q - 8'd1;
                if (drain_q == 8'd1) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (active) begin
            cyc_d    = cyc_q + CNT_W'(1);
            ins_d    = ins_q + CNT_W'(ins_ev);
            wr_ptr_d = wr_ptr_q + IW'(n_wr);
            // Any write past a full buffer overwrites the oldest entry.
            if (nv_sum > DEPTH_X) begin
                nv_d      = DEPTH_N;
                wrapped_d = 1'b1;
            end else begin
                nv_d = nv_sum[NW-1:0];
            end
        end

        if (clr) begin
            state_d   = ST_RUN;
            drain_d   = '0;
            cyc_d     = '0;
            ins_d     = '0;
            wr_ptr_d  = '0;
            nv_d      = '0;
            wrapped_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_RUN;
            drain_q   <= '0;
            cyc_q     <= '0;
            ins_q     <= '0;
            wr_ptr_q  <= '0;
            nv_q      <= '0;
            wrapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            drain_q   <= drain_d;
            cyc_q     <= cyc_d;
            ins_q     <= ins_d;
            wr_ptr_q  <= wr_ptr_d;
            nv_q      <= nv_d;
            wrapped_q <= wrapped_d;
        end
    end

    // Port A takes the instruction when present, else a lone memory write.
    assign wa_en = (ins_ev || mem_ev) && !clr;

`ifdef TRACE_MEMWR_EN
    logic               wb_en;
    logic [IW-1:0]      wb_addr;
    logic [ENTRY_W-1:0] wb_data;

    assign wa_data = ins_ev
                   ? {TAG_INSTR, bus.ret_pc, bus.ret_instr}
                   : {TAG_MEMWR, bus.mem_addr, bus.mem_wdata};
    assign wb_en   = ins_ev && mem_ev && !clr;
    assign wb_addr = wr_ptr_q + IW'(1);
    assign wb_data = {TAG_MEMWR, bus.mem_addr, bus.mem_wdata};
`else
    assign wa_data = {bus.ret_pc, bus.ret_instr};
`endif

    // Once wrapped, the oldest entry sits at the write pointer.
    assign raddr = (wrapped_q ? wr_ptr_q : '0) + rd_idx;
    assign rd_en = ({1'b0, rd_idx} < nv_q);

    mrisc_trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_ram (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .clr     (clr),
        .wa_en   (wa_en),
        .wa_addr (wr_ptr_q),
        .wa_data (wa_data),
`ifdef TRACE_MEMWR_EN
        .wb_en   (wb_en),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
`endif
        .rd_en   (rd_en),
        .rd_addr (raddr),
        .rd_data (rd_word)
    );

`ifdef TRACE_MEMWR_EN
    assign {rd_tag, rd_addr, rd_data} = rd_word;
`else
    assign rd_tag             = TAG_INSTR;
    assign {rd_addr, rd_data} = rd_word;
`endif

    assign cyc_cnt = cyc_q;
    assign ins_cnt = ins_q;
    assign n_valid = nv_q;
    assign wrapped = wrapped_q;
    assign halted  = (state_q != ST_RUN);
    assign done    = (state_q == ST_DONE);

endmodule
